ser_word_loader: RTL and testbench



---
 rtl/ser_pkg.sv | 11 +
 rtl/ser_shift_reg.sv | 38 +++
 rtl/ser_word_loader.sv | 129 ++++++++++++
 tb/tb_ser_word_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared types and constants for the serial word loader.
package ser_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Matches the width of the downstream register block.
  localparam int DEFAULT_WIDTH = 32;
endpackage

// File: rtl/ser_shift_reg.sv
// WIDTH-bit serial shifter; exposes the value it would hold after shifting din,
// so the top can capture the completed word on the same edge as the last bit.
module ser_shift_reg
  import ser_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             r,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] shifted
);

  logic [WIDTH-1:0] q_reg;

  // LSB-first enters at the top and walks down, so the first bit ends in bit 0.
  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign shifted = {din, q_reg[WIDTH-1:1]};
    end else begin : g_msb_first
      assign shifted = {q_reg[WIDTH-2:0], din};
    end
  endgenerate

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      q_reg <= '0;
    end else if (clr) begin
      q_reg <= '0;
    end else if (en) begin
      q_reg <= shifted;
    end
  end

endmodule

// File: rtl/ser_word_loader.sv
// Serial-to-parallel word assembler with start/valid framing and a
// valid/ready handshake toward the register block.
module ser_word_loader
  import ser_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             r,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_vld,
  output logic [WIDTH-1:0] word_out,
  output logic             word_vld,
  input  logic             word_rdy,
  output logic             busy,
  output logic [CW-1:0]    bit_cnt,
  output logic             abort,
  output logic             ovf
);

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] word_reg, word_next;
  logic             vld_reg, vld_next;
  logic             busy_reg;
  logic             abort_reg, abort_next;
  logic             ovf_reg, ovf_next;
  logic             clr, en;
  logic [WIDTH-1:0] shifted;

  ser_shift_reg #(
    .WIDTH    (WIDTH),
    .LSB_FIRST(LSB_FIRST)
  ) u_shift (
    .clk    (clk),
    .r      (r),
    .clr    (clr),
    .en     (en),
    .din    (sin),
    .shifted(shifted)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    word_next  = word_reg;
    vld_next   = vld_reg;
    abort_next = 1'b0;
    ovf_next   = 1'b0;
    clr        = 1'b0;
    en         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
          cnt_next   = '0;
          clr        = 1'b1;
        end
      end
      SHIFT: begin
        // A restart wins over a bit arriving on the same edge.
        if (start) begin
          cnt_next   = '0;
          clr        = 1'b1;
          abort_next = 1'b1;
        end else if (sin_vld) begin
          en = 1'b1;
          if (cnt_reg == CW'(WIDTH - 1)) begin
            word_next  = shifted;
            vld_next   = 1'b1;
            cnt_next   = '0;
            state_next = FULL;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      FULL: begin
        ovf_next = sin_vld;
        if (word_rdy) begin
          vld_next = 1'b0;
          if (start) begin
            state_next = SHIFT;
            cnt_next   = '0;
            clr        = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        vld_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      word_reg  <= '0;
      vld_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      abort_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      word_reg  <= word_next;
      vld_reg   <= vld_next;
      busy_reg  <= (state_next != IDLE);
      abort_reg <= abort_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign word_out = word_reg;
  assign word_vld = vld_reg;
  assign busy     = busy_reg;
  assign bit_cnt  = cnt_reg;
  assign abort    = abort_reg;
  assign ovf      = ovf_reg;

endmodule

// File: tb/tb_ser_word_loader.sv
// Scoreboard bench: two loaders (LSB-first and MSB-first) share one stimulus
// stream; expected words are queued at send time and popped by a monitor.
module tb_ser_word_loader;
  localparam int W = 32;

  logic clk = 1'b0;
  logic r = 1'b0;
  logic start = 1'b0, sin = 1'b0, sin_vld = 1'b0, word_rdy = 1'b0;

  logic [W-1:0] word_out_l, word_out_m;
  logic         word_vld_l, word_vld_m, busy_l, busy_m;
  logic         abort_l, abort_m, ovf_l, ovf_m;
  logic [4:0]   bit_cnt_l, bit_cnt_m;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_l[$], exp_m[$];
  logic [W-1:0] hold_l = '0, hold_m = '0;
  logic prev_l = 1'b0, prev_m = 1'b0;
  int abort_cnt_l = 0, abort_cnt_m = 0, ovf_cnt_l = 0, ovf_cnt_m = 0;
  int exp_abort = 0, exp_ovf = 0;

  always #5 clk = ~clk;

  ser_word_loader #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .r(r), .start(start), .sin(sin), .sin_vld(sin_vld),
    .word_out(word_out_l), .word_vld(word_vld_l), .word_rdy(word_rdy),
    .busy(busy_l), .bit_cnt(bit_cnt_l), .abort(abort_l), .ovf(ovf_l)
  );

  ser_word_loader #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .r(r), .start(start), .sin(sin), .sin_vld(sin_vld),
    .word_out(word_out_m), .word_vld(word_vld_m), .word_rdy(word_rdy),
    .busy(busy_m), .bit_cnt(bit_cnt_m), .abort(abort_m), .ovf(ovf_m)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // bits[k] is the k-th received bit; place it by the ordering rule.
  function automatic logic [W-1:0] model_word(input logic [W-1:0] bits, input bit lsb_first);
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < W; k++)
      if (bits[k]) w = w | (W'(1) << (lsb_first ? k : W - 1 - k));
    return w;
  endfunction

  task automatic drive(input logic st, input logic s, input logic sv, input logic rdy);
    start = st; sin = s; sin_vld = sv; word_rdy = rdy;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops on each word_vld rise, then checks the word stays put.
  always @(posedge clk) begin
    #2;
    if (r) begin
      prev_l = 1'b0;
      prev_m = 1'b0;
    end else begin
      if (word_vld_l && !prev_l) begin
        if (exp_l.size() == 0) chk("unexpected_word_l", exp_l.size(), 1);
        else begin
          hold_l = exp_l.pop_front();
          chk("word_l", word_out_l, hold_l);
        end
      end else if (word_vld_l) chk("hold_l", word_out_l, hold_l);
      if (word_vld_m && !prev_m) begin
        if (exp_m.size() == 0) chk("unexpected_word_m", exp_m.size(), 1);
        else begin
          hold_m = exp_m.pop_front();
          chk("word_m", word_out_m, hold_m);
        end
      end else if (word_vld_m) chk("hold_m", word_out_m, hold_m);
      prev_l = word_vld_l;
      prev_m = word_vld_m;
      if (abort_l) abort_cnt_l++;
      if (abort_m) abort_cnt_m++;
      if (ovf_l) ovf_cnt_l++;
      if (ovf_m) ovf_cnt_m++;
    end
  end

  task automatic send_frame(input logic [W-1:0] v, input int gap_pct, input int abort_at,
                            input bit skip_start);
    if (!skip_start) drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("busy_after_start", busy_l, 1);
    chk("cnt_after_start", bit_cnt_l, 0);
    if (abort_at >= 0) begin
      for (int k = 0; k < abort_at; k++) drive(1'b0, 1'($urandom), 1'b1, 1'b0);
      drive(1'b1, 1'($urandom), 1'b1, 1'b0);
      exp_abort++;
      chk("abort_pulse_l", abort_l, 1);
      chk("abort_pulse_m", abort_m, 1);
      chk("cnt_after_abort", bit_cnt_l, 0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("abort_single", abort_l, 0);
    end
    for (int k = 0; k < W; k++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        drive(1'b0, 1'($urandom), 1'b0, 1'b0);
        chk("cnt_gap", bit_cnt_l, k);
      end
      if (k == W - 1) begin
        exp_l.push_back(model_word(v, 1'b1));
        exp_m.push_back(model_word(v, 1'b0));
      end
      drive(1'b0, v[k], 1'b1, 1'b0);
      if (k < W - 1) chk("cnt_step", bit_cnt_m, k + 1);
    end
    chk("vld_latency_l", word_vld_l, 1);
    chk("vld_latency_m", word_vld_m, 1);
    chk("cnt_full", bit_cnt_l, 0);
    chk("busy_full", busy_l, 1);
  endtask

  task automatic hold_and_accept(input int hold, input int n_ovf, input bit with_start);
    logic sv, st;
    for (int i = 0; i < hold; i++) begin
      sv = (i < n_ovf);
      st = 1'($urandom);
      drive(st, 1'($urandom), sv, 1'b0);
      if (sv) exp_ovf++;
      chk("ovf_pulse_l", ovf_l, sv);
      chk("ovf_pulse_m", ovf_m, sv);
      chk("vld_held", word_vld_l, 1);
      chk("no_abort_full", abort_l, 0);
    end
    drive(with_start, 1'b0, 1'b0, 1'b1);
    chk("vld_drop_l", word_vld_l, 0);
    chk("vld_drop_m", word_vld_m, 0);
    chk("busy_after_accept", busy_l, with_start);
    chk("cnt_after_accept", bit_cnt_l, 0);
    chk("ovf_after_accept", ovf_l, 0);
  endtask

  initial begin
    logic [W-1:0] v;
    bit b2b;
    int hold;
    #1 r = 1'b1;
    #1;
    chk("rst_word", word_out_l, 0);
    chk("rst_vld", word_vld_l, 0);
    chk("rst_busy", busy_m, 0);
    chk("rst_flags", {abort_l, ovf_l, bit_cnt_l}, 0);
    @(posedge clk);
    #1 r = 1'b0;

    send_frame(32'hDEADBEEF, 0, -1, 1'b0);
    hold_and_accept(5, 0, 1'b0);

    send_frame(32'h00000001, 0, -1, 1'b0);
    hold_and_accept(1, 0, 1'b0);

    send_frame(32'h12345678, 50, -1, 1'b0);
    hold_and_accept(2, 0, 1'b0);

    send_frame(32'h0000FFFF, 0, 7, 1'b0);
    hold_and_accept(0, 0, 1'b0);

    // IDLE ignores serial data.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'($urandom), 1'b1, 1'b0);
      chk("idle_busy", busy_l, 0);
      chk("idle_ovf", ovf_l, 0);
    end

    send_frame(32'hA5A5C3C3, 0, -1, 1'b0);
    hold_and_accept(3, 3, 1'b1);
    send_frame(32'h0F0F1234, 20, -1, 1'b1);
    hold_and_accept(0, 0, 1'b0);

    // Asynchronous reset in the middle of a frame.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) drive(1'b0, 1'($urandom), 1'b1, 1'b0);
    chk("cnt_pre_reset", bit_cnt_l, 10);
    #2 r = 1'b1;
    #1;
    chk("async_rst_cnt", bit_cnt_l, 0);
    chk("async_rst_busy", busy_l, 0);
    chk("async_rst_word_l", word_out_l, 0);
    chk("async_rst_word_m", word_out_m, 0);
    @(posedge clk);
    #1 r = 1'b0;
    chk("post_reset_idle", busy_m, 0);
    send_frame(32'hCAFEF00D, 10, -1, 1'b0);
    hold_and_accept(1, 1, 1'b0);

    b2b = 1'b0;
    for (int f = 0; f < 25; f++) begin
      v = $urandom;
      send_frame(v, $urandom_range(0, 60),
                 ($urandom_range(3) == 0) ? int'($urandom_range(0, W - 2)) : -1, b2b);
      hold = $urandom_range(0, 4);
      b2b = 1'($urandom);
      hold_and_accept(hold, $urandom_range(0, hold), b2b);
      if (!b2b) begin
        for (int i = 0; i < 2; i++) drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
        chk("rand_idle_busy", busy_l, 0);
      end
    end
    if (b2b) begin
      send_frame($urandom, 30, -1, 1'b1);
      hold_and_accept(1, 0, 1'b0);
    end

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("queue_empty_l", exp_l.size(), 0);
    chk("queue_empty_m", exp_m.size(), 0);
    chk("abort_total_l", abort_cnt_l, exp_abort);
    chk("abort_total_m", abort_cnt_m, exp_abort);
    chk("ovf_total_l", ovf_cnt_l, exp_ovf);
    chk("ovf_total_m", ovf_cnt_m, exp_ovf);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
